pixel_burst_packer: RTL

PIXEL_BURST_PACKER -- requirements
Module: pixel_burst_packer

---
 rtl/pixel_burst_packer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pixel_burst_packer.sv
// Packs an RGB565 fragment stream into 128-bit words, gathers BURST_LEN words per
// ping-pong bank and drains each full bank as one memory write burst.
//
// state | meaning
// IDLE  | no burst in flight; waits for the oldest bank to be pending
// CMD   | burst command presented, held until cmd_ready
// DATA  | bank words presented one beat at a time, wdata_last on the final beat
module pixel_burst_packer #(
    parameter int          H_DISP    = 1280,
    parameter int          V_DISP    = 720,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter int          BURST_LEN = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frag_valid,
    output logic         frag_ready,
    input  logic [15:0]  frag_x,
    input  logic [15:0]  frag_y,
    input  logic [15:0]  frag_rgb,
    output logic         cmd_valid,
    input  logic         cmd_ready,
    output logic [31:0]  cmd_addr,
    output logic [7:0]   cmd_len,
    output logic         wdata_valid,
    input  logic         wdata_ready,
    output logic [127:0] wdata,
    output logic         wdata_last,
    output logic         frame_done,
    output logic         err_misalign
);
    localparam int AW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [AW-1:0] LAST_WORD = AW'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} drain_state_t;
    drain_state_t state, state_nxt;

    logic [127:0]  bank_mem [2][BURST_LEN];
    logic [31:0]   bank_addr [2];
    logic [1:0]    bank_full;
    logic [1:0]    bank_has_last;
    logic [127:0]  cur_word;
    logic [127:0]  word_nxt;
    logic [AW-1:0] fill_word;
    logic [AW-1:0] beat;
    logic          fill_bank;
    logic          drain_bank;
    logic          bank_first;
    logic [15:0]   exp_x;
    logic [15:0]   exp_y;

    logic          accept;
    logic          word_done;
    logic          bank_done;
    logic          beat_acc;
    logic          release_bank;
    logic          is_last_pix;
    logic [1:0]    full_nxt;
    logic          fill_bank_nxt;
    logic [31:0]   pix_addr;

    assign accept       = frag_valid & frag_ready;
    assign word_done    = accept & (frag_x[2:0] == 3'd7);
    assign bank_done    = word_done & (fill_word == LAST_WORD);
    assign beat_acc     = (state == DATA) & wdata_ready;
    assign release_bank = beat_acc & (beat == LAST_WORD);
    assign is_last_pix  = (frag_x == 16'(H_DISP - 1)) && (frag_y == 16'(V_DISP - 1));
    assign pix_addr     = FB_BASE + ((32'(frag_y) * 32'(H_DISP) + 32'(frag_x)) << 1);

    always_comb begin
        word_nxt = cur_word;
        word_nxt[{frag_x[2:0], 4'b0000} +: 16] = frag_rgb;
    end

    // A bank released in the same cycle the other completes is immediately fillable.
    always_comb begin
        full_nxt = bank_full;
        if (release_bank) full_nxt[drain_bank] = 1'b0;
        if (bank_done) full_nxt[fill_bank] = 1'b1;
    end
    assign fill_bank_nxt = bank_done ? ~fill_bank : fill_bank;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bank_full[drain_bank]) state_nxt = CMD;
            CMD:     if (cmd_ready) state_nxt = DATA;
            DATA:    if (release_bank) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_valid   = (state == CMD);
    assign wdata_valid = (state == DATA);
    assign wdata_last  = (state == DATA) && (beat == LAST_WORD);
    assign cmd_addr    = bank_addr[drain_bank];
    assign cmd_len     = 8'(BURST_LEN - 1);
    assign wdata       = bank_mem[drain_bank][beat];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bank_full     <= '0;
            bank_has_last <= '0;
            cur_word      <= '0;
            fill_word     <= '0;
            beat          <= '0;
            fill_bank     <= 1'b0;
            drain_bank    <= 1'b0;
            bank_first    <= 1'b1;
            exp_x         <= '0;
            exp_y         <= '0;
            frag_ready    <= 1'b1;
            frame_done    <= 1'b0;
            err_misalign  <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                bank_addr[b] <= '0;
                for (int w = 0; w < BURST_LEN; w++) bank_mem[b][w] <= '0;
            end
        end else begin
            state      <= state_nxt;
            bank_full  <= full_nxt;
            fill_bank  <= fill_bank_nxt;
            frag_ready <= ~full_nxt[fill_bank_nxt];
            frame_done <= release_bank & bank_has_last[drain_bank];
            if (accept) begin
                cur_word   <= word_done ? '0 : word_nxt;
                bank_first <= bank_done;
                if (word_done) begin
                    bank_mem[fill_bank][fill_word] <= word_nxt;
                    fill_word <= bank_done ? '0 : fill_word + AW'(1);
                end
                if (bank_first) bank_addr[fill_bank] <= pix_addr;
                if (is_last_pix) bank_has_last[fill_bank] <= 1'b1;
                else if (bank_first) bank_has_last[fill_bank] <= 1'b0;
                if (frag_x != exp_x || frag_y != exp_y) err_misalign <= 1'b1;
                // Expected coordinate always follows the pixel just taken, so it resyncs on a gap.
                if (frag_x == 16'(H_DISP - 1)) begin
                    exp_x <= '0;
                    exp_y <= (frag_y == 16'(V_DISP - 1)) ? 16'd0 : frag_y + 16'd1;
                end else begin
                    exp_x <= frag_x + 16'd1;
                    exp_y <= frag_y;
                end
            end
            if (beat_acc) beat <= (beat == LAST_WORD) ? '0 : beat + AW'(1);
            if (release_bank) drain_bank <= ~drain_bank;
        end
    end
endmodule
